// File: rtl/usart_rx_fifo.sv
`timescale 1ns/1ps
// Receive buffer behind usart_rx. It takes one byte per available/acknowledge handshake
// and queues it with its framing-error flag in a first-word-fall-through FIFO.
module usart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  comm_clock,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_available,
    input  logic                  rx_error,
    output logic                  rx_acknowledge,
    input  logic                  rd_strobe,
    output logic [7:0]            rd_data,
    output logic                  rd_error,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  clear,
    output logic                  fsm_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                state;
    state_t                state_next;
    logic                  capture;
    logic                  pop;
    logic                  write;
    logic                  drop;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [8:0]            mem [DEPTH];
    logic [8:0]            head;

    // Handshake: usart_rx raises rx_available with stable data; we capture on the
    // first IDLE edge, hold rx_acknowledge until rx_available falls, then return to IDLE.
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_available) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!rx_available) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_acknowledge = (state == ACK);
    assign fsm_state      = (state == ACK);

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign pop   = rd_strobe && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign write = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (write && !pop)      count <= count + 1'b1;
            else if (!write && pop) count <= count - 1'b1;
            if (drop) overrun <= 1'b1;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (write && !clear) mem[wr_ptr] <= {rx_error, rx_data};
    end

    // Storage is unreset; mask the head while empty so outputs are defined.
    assign head     = mem[rd_ptr];
    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign rd_error = empty ? 1'b0  : head[8];

endmodule

// File: tb/tb_usart_rx_fifo.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for usart_rx_fifo: a queue model of the FIFO is
// updated once per cycle from the stimulus intent and compared against the DUT.
module tb_usart_rx_fifo;
    localparam int DEPTH = 16;

    logic       comm_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_available = 1'b0;
    logic       rx_error = 1'b0;
    logic       rx_acknowledge;
    logic       rd_strobe = 1'b0;
    logic [7:0] rd_data;
    logic       rd_error;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clear = 1'b0;
    logic       fsm_state;

    int         checks = 0;
    int         errors = 0;
    bit         present_new = 1'b0;
    logic [8:0] exp_q[$];
    bit         m_ovr = 1'b0;
    bit         ack_exp = 1'b0;

    usart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .comm_clock(comm_clock), .reset_n(reset_n), .rx_data(rx_data),
        .rx_available(rx_available), .rx_error(rx_error), .rx_acknowledge(rx_acknowledge),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .rd_error(rd_error), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .clear(clear), .fsm_state(fsm_state)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples settled pre-edge values, compares against the model, then
    // advances the model by what the coming edge will do.
    always begin
        @(negedge comm_clock);
        #2;
        if (!reset_n) begin
            exp_q.delete();
            m_ovr   = 1'b0;
            ack_exp = 1'b0;
        end else begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
            check("full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("ack", 32'(rx_acknowledge), 32'(ack_exp));
            if (exp_q.size() > 0) begin
                check("rd_data", 32'(rd_data), 32'(exp_q[0][7:0]));
                check("rd_error", 32'(rd_error), 32'(exp_q[0][8]));
            end
            if (clear) begin
                exp_q.delete();
                m_ovr = 1'b0;
            end else begin
                if (rd_strobe && exp_q.size() > 0) void'(exp_q.pop_front());
                if (present_new) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({rx_error, rx_data});
                    else                      m_ovr = 1'b1;
                end
            end
            ack_exp = present_new ? 1'b1 : (rx_available ? ack_exp : 1'b0);
        end
    end

    task automatic cyc();
        @(negedge comm_clock);
        #1;
        rd_strobe   = 1'b0;
        clear       = 1'b0;
        present_new = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic e, input int hold,
                        input bit pop_too, input bit clr_too);
        cyc();
        rx_data      = d;
        rx_error     = e;
        rx_available = 1'b1;
        present_new  = 1'b1;
        rd_strobe    = pop_too;
        clear        = clr_too;
        repeat (hold - 1) cyc();
        cyc();
        rx_available = 1'b0;
        cyc();
    endtask

    task automatic pop_one();
        cyc();
        rd_strobe = 1'b1;
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_ack", 32'(rx_acknowledge), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_error", 32'(rd_error), 0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Single byte held long: exactly one write.
        send(8'hA5, 1'b0, 20, 1'b0, 1'b0);
        repeat (2) cyc();
        check("single_count", 32'(count), 1);
        check("single_data", 32'(rd_data), 32'hA5);
        pop_one();
        cyc();

        // Fill past depth, then drain.
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0, 1, 1'b0, 1'b0);
        cyc();
        check("fill_full", 32'(full), 1);
        check("fill_overrun", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) pop_one();
        cyc();
        check("drain_empty", 32'(empty), 1);
        cyc();
        clear = 1'b1;
        cyc();

        // Capture and pop on the same edge while full.
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'(i & 1), 1, 1'b0, 1'b0);
        send(8'hEE, 1'b0, 1, 1'b1, 1'b0);
        check("simul_count", 32'(count), 16);
        check("simul_overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) pop_one();
        cyc();

        // Error flag travels with its byte.
        send(8'h31, 1'b1, 2, 1'b0, 1'b0);
        send(8'h32, 1'b0, 2, 1'b0, 1'b0);
        pop_one();
        pop_one();
        cyc();

        // Interleaved random traffic across pointer wrap, with empty pops.
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) != 0) pop_one();
        end
        repeat (20) pop_one();
        cyc();
        check("underflow_count", 32'(count), 0);
        check("underflow_empty", 32'(empty), 1);

        // Clear together with a capture at count 5 with overrun set.
        for (int i = 0; i < 17; i++) send(8'(8'h80 + i), 1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) pop_one();
        cyc();
        check("preclear_count", 32'(count), 5);
        check("preclear_overrun", 32'(overrun), 1);
        send(8'h77, 1'b0, 1, 1'b0, 1'b1);
        check("clear_count", 32'(count), 0);
        check("clear_overrun", 32'(overrun), 0);
        check("clear_empty", 32'(empty), 1);

        // Reset in the middle of an acknowledge.
        cyc();
        rx_data      = 8'h5A;
        rx_error     = 1'b0;
        rx_available = 1'b1;
        present_new  = 1'b1;
        cyc();
        cyc();
        check("ack_before_reset", 32'(rx_acknowledge), 1);
        reset_n = 1'b0;
        #1;
        check("ack_async_drop", 32'(rx_acknowledge), 0);
        check("reset_count", 32'(count), 0);
        cyc();
        cyc();
        reset_n     = 1'b1;
        present_new = 1'b1;
        cyc();
        rx_available = 1'b0;
        cyc();
        cyc();
        check("rerx_count", 32'(count), 1);
        check("rerx_data", 32'(rd_data), 32'h5A);
        pop_one();
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
